// File: rtl/alu32_bist_pkg.sv
// Shared types, constants and the LFSR/MISR step function for the ALU self-test sequencer.
package alu32_bist_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain,
        StDone
    } state_e;

    localparam logic [31:0] POLY      = 32'h8020_0003;
    localparam logic [31:0] MISR_INIT = 32'hFFFF_FFFF;
    localparam logic [31:0] OPER_ONES = 32'hFFFF_FFFF;
    localparam logic [31:0] OPER_ZERO = 32'h0000_0000;

    // Galois right-shift step, shared by the operand LFSRs and the MISR.
    function automatic logic [31:0] step(input logic [31:0] x, input logic [31:0] poly = POLY);
        return x[0] ? ((x >> 1) ^ poly) : (x >> 1);
    endfunction

endpackage

// File: rtl/alu32_bist_if.sv
// ALU operand/control bus; the self-test sequencer is the master, the ALU the slave.
interface alu32_bist_if;

    logic [31:0] oA;
    logic [31:0] oB;
    logic [2:0]  oCtrl;
    logic [31:0] iOut;
    logic        iCarry;
    logic        iZero;

    modport master (
        output oA,
        output oB,
        output oCtrl,
        input  iOut,
        input  iCarry,
        input  iZero
    );

    modport slave (
        input  oA,
        input  oB,
        input  oCtrl,
        output iOut,
        output iCarry,
        output iZero
    );

endinterface

// File: rtl/alu32_bist_lfsr32.sv
// 32-bit Galois operand LFSR with synchronous seed load and step enable.
module lfsr32
    import alu32_bist_pkg::*;
#(
    parameter logic [31:0] SEED = 32'h0000_0001,
    parameter logic [31:0] TAPS = POLY
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        en,
    output logic [31:0] q,
    output logic [31:0] nxt
);

    // The next value is exported so the owner can register it as an operand in the same edge.
    assign nxt = step(q, TAPS);

    always_ff @(posedge clk) begin
        if (rst || load) begin
            q <= SEED;
        end else if (en) begin
            q <= nxt;
        end
    end

endmodule

// File: rtl/alu32_bist.sv
// ALU built-in self-test: sweeps all opcodes over N_VEC operand vectors and
// compacts every response into a MISR signature checked against GOLDEN.
module alu32_bist
    import alu32_bist_pkg::*;
#(
    parameter int unsigned N_VEC   = 16,
    parameter int unsigned ALU_LAT = 1,
    parameter logic [31:0] SEED_A  = 32'hACE1_2468,
    parameter logic [31:0] SEED_B  = 32'h1357_9BDF,
    parameter logic [31:0] GOLDEN  = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                iStart,
    alu32_bist_if.master        alu,
    output logic                oBusy,
    output logic                oDone,
    output logic                oPass,
    output logic [31:0]         oSig
);

    localparam int unsigned     VW        = $clog2(N_VEC) + 1;
    localparam int unsigned     DRAIN_CYC = (ALU_LAT > 1) ? ALU_LAT : 1;
    localparam int unsigned     DW        = $clog2(DRAIN_CYC + 1);
    localparam logic [VW-1:0]   LAST_VEC  = VW'(N_VEC - 1);
    localparam logic [DW-1:0]   LAST_DRN  = DW'(DRAIN_CYC - 1);

    state_e          state_q;
    logic [VW-1:0]   vec_q;
    logic [2:0]      op_q;
    logic [DW-1:0]   drain_q;
    logic [31:0]     misr_q;

    logic            start_ok;
    logic            issuing;
    logic            last_op;
    logic            last_issue;
    logic            vec_adv;
    logic            lfsr_en;
    logic            capture;
    logic [VW-1:0]   vec_nxt;
    logic [31:0]     lfsr_a_q;
    logic [31:0]     lfsr_a_nxt;
    logic [31:0]     lfsr_b_q;
    logic [31:0]     lfsr_b_nxt;
    logic [31:0]     a_next;
    logic [31:0]     b_next;
    logic [31:0]     resp;
    logic [31:0]     misr_upd;

    assign start_ok   = iStart && ((state_q == StIdle) || (state_q == StDone));
    assign issuing    = (state_q == StIssue);
    assign last_op    = (op_q == 3'd7);
    assign last_issue = issuing && last_op && (vec_q == LAST_VEC);
    assign vec_adv    = issuing && last_op && !last_issue;
    assign vec_nxt    = vec_q + VW'(1);
    // Vector 2 consumes the seed itself; the LFSRs only move on advances past it.
    assign lfsr_en    = vec_adv && (vec_q >= VW'(2));

    assign resp     = alu.iOut ^ {alu.iCarry, alu.iZero, 30'b0};
    assign misr_upd = capture ? (step(misr_q) ^ resp) : misr_q;
    assign oSig     = misr_q;

    lfsr32 #(
        .SEED (SEED_A),
        .TAPS (POLY)
    ) u_lfsr_a (
        .clk  (clk),
        .rst  (rst),
        .load (start_ok),
        .en   (lfsr_en),
        .q    (lfsr_a_q),
        .nxt  (lfsr_a_nxt)
    );

    lfsr32 #(
        .SEED (SEED_B),
        .TAPS (POLY)
    ) u_lfsr_b (
        .clk  (clk),
        .rst  (rst),
        .load (start_ok),
        .en   (lfsr_en),
        .q    (lfsr_b_q),
        .nxt  (lfsr_b_nxt)
    );

    // Operands for the vector about to be issued after an advance.
    always_comb begin
        a_next = OPER_ONES;
        b_next = OPER_ONES;
        if (vec_nxt == VW'(1)) begin
            b_next = OPER_ZERO;
        end else if (vec_nxt >= VW'(2)) begin
            a_next = lfsr_en ? lfsr_a_nxt : lfsr_a_q;
            b_next = lfsr_en ? lfsr_b_nxt : lfsr_b_q;
        end
    end

    // Response capture is aligned to the ALU latency by a valid shift register.
    if (ALU_LAT == 0) begin : g_comb
        assign capture = issuing;
    end else begin : g_pipe
        logic [ALU_LAT-1:0] vld_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q <= '0;
            end else begin
                vld_q <= ALU_LAT'({vld_q, issuing});
            end
        end

        assign capture = vld_q[ALU_LAT-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            vec_q     <= '0;
            op_q      <= '0;
            drain_q   <= '0;
            misr_q    <= '0;
            alu.oA    <= '0;
            alu.oB    <= '0;
            alu.oCtrl <= '0;
            oBusy     <= 1'b0;
            oDone     <= 1'b0;
            oPass     <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start_ok) begin
                        state_q   <= StIssue;
                        vec_q     <= '0;
                        op_q      <= '0;
                        drain_q   <= '0;
                        misr_q    <= MISR_INIT;
                        alu.oA    <= OPER_ONES;
                        alu.oB    <= OPER_ONES;
                        alu.oCtrl <= 3'd0;
                        oBusy     <= 1'b1;
                        oDone     <= 1'b0;
                        oPass     <= 1'b0;
                    end
                end
                StIssue: begin
                    misr_q <= misr_upd;
                    if (last_issue) begin
                        state_q   <= StDrain;
                        alu.oA    <= '0;
                        alu.oB    <= '0;
                        alu.oCtrl <= '0;
                    end else begin
                        op_q      <= op_q + 3'd1;
                        alu.oCtrl <= op_q + 3'd1;
                        if (last_op) begin
                            vec_q  <= vec_nxt;
                            alu.oA <= a_next;
                            alu.oB <= b_next;
                        end
                    end
                end
                StDrain: begin
                    misr_q <= misr_upd;
                    if (drain_q == LAST_DRN) begin
                        state_q <= StDone;
                        drain_q <= '0;
                        oBusy   <= 1'b0;
                        oDone   <= 1'b1;
                        oPass   <= (misr_upd == GOLDEN);
                    end else begin
                        drain_q <= drain_q + DW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_alu32_bist.sv
// Directed self-checking bench for alu32_bist: three instances cover the
// registered-ALU run, the two-vector corner sweep and the combinational-ALU run.
module tb_alu32_bist;

    localparam logic [31:0] SEED_A = 32'hACE1_2468;
    localparam logic [31:0] SEED_B = 32'h1357_9BDF;
    localparam logic [31:0] ONES   = 32'hFFFF_FFFF;

    function automatic logic [31:0] lstep(input logic [31:0] x);
        logic [31:0] y;
        y = x >> 1;
        if (x[0]) y = y ^ 32'h8020_0003;
        return y;
    endfunction

    // Reference ALU: returns {carry, zero, result}.
    function automatic logic [33:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] c, input bit fault_en);
        logic [32:0] w;
        logic [31:0] y;
        logic        cy;
        cy = 1'b0;
        w  = '0;
        y  = '0;
        case (c)
            3'd0: begin w = {1'b0, a} + {1'b0, b}; y = w[31:0]; cy = w[32]; end
            3'd1: begin w = {1'b0, a} - {1'b0, b}; y = w[31:0]; cy = w[32]; end
            3'd2: y = a & b;
            3'd3: y = a | b;
            3'd4: y = a ^ b;
            3'd5: y = ~(a | b);
            3'd6: y = {31'b0, ($signed(a) < $signed(b))};
            default: y = a << b[4:0];
        endcase
        if (fault_en && (c == 3'd0)) cy = 1'b0;
        return {cy, (y == 32'h0), y};
    endfunction

    function automatic logic [31:0] calc_sig(input int nvec, input bit fault_en);
        logic [31:0] m, la, lb, a, b;
        logic [33:0] r;
        m  = 32'hFFFF_FFFF;
        la = SEED_A;
        lb = SEED_B;
        a  = '0;
        b  = '0;
        for (int v = 0; v < nvec; v++) begin
            if (v == 0) begin
                a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
            end else if (v == 1) begin
                a = 32'hFFFF_FFFF; b = 32'h0000_0000;
            end else begin
                a = la; b = lb; la = lstep(la); lb = lstep(lb);
            end
            for (int c = 0; c < 8; c++) begin
                r = alu_fn(a, b, 3'(c), fault_en);
                m = lstep(m) ^ r[31:0] ^ {r[33], r[32], 30'b0};
            end
        end
        return m;
    endfunction

    localparam logic [31:0] GOLD16 = calc_sig(16, 1'b0);

    int checks;
    int failures;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst1, start1, fault, busy1, done1, pass1;
    logic        rst2, start2, busy2, done2, pass2;
    logic        rst3, start3, busy3, done3, pass3;
    logic [31:0] sig1, sig2, sig3;
    logic [33:0] r1_q, r2_q, r3;

    alu32_bist_if bus1 ();
    alu32_bist_if bus2 ();
    alu32_bist_if bus3 ();

    always @(posedge clk) r1_q <= alu_fn(bus1.oA, bus1.oB, bus1.oCtrl, fault);
    always @(posedge clk) r2_q <= alu_fn(bus2.oA, bus2.oB, bus2.oCtrl, 1'b0);
    assign r3 = alu_fn(bus3.oA, bus3.oB, bus3.oCtrl, 1'b0);

    assign bus1.iOut = r1_q[31:0];
    assign bus1.iZero = r1_q[32];
    assign bus1.iCarry = r1_q[33];
    assign bus2.iOut = r2_q[31:0];
    assign bus2.iZero = r2_q[32];
    assign bus2.iCarry = r2_q[33];
    assign bus3.iOut = r3[31:0];
    assign bus3.iZero = r3[32];
    assign bus3.iCarry = r3[33];

    alu32_bist #(.N_VEC(16), .ALU_LAT(1), .SEED_A(SEED_A), .SEED_B(SEED_B), .GOLDEN(GOLD16)) u_dut1 (
        .clk(clk), .rst(rst1), .iStart(start1), .alu(bus1),
        .oBusy(busy1), .oDone(done1), .oPass(pass1), .oSig(sig1)
    );

    alu32_bist #(.N_VEC(2), .ALU_LAT(1), .SEED_A(SEED_A), .SEED_B(SEED_B), .GOLDEN(32'h0)) u_dut2 (
        .clk(clk), .rst(rst2), .iStart(start2), .alu(bus2),
        .oBusy(busy2), .oDone(done2), .oPass(pass2), .oSig(sig2)
    );

    alu32_bist #(.N_VEC(16), .ALU_LAT(0), .SEED_A(SEED_A), .SEED_B(SEED_B), .GOLDEN(GOLD16)) u_dut3 (
        .clk(clk), .rst(rst3), .iStart(start3), .alu(bus3),
        .oBusy(busy3), .oDone(done3), .oPass(pass3), .oSig(sig3)
    );

    task automatic reset1();
        rst1 = 1'b1;
        start1 = 1'b0;
        @(negedge clk);
        rst1 = 1'b0;
    endtask

    // Start is sampled at the next rising edge (E0); returns in cycle 1.
    task automatic launch1();
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
    endtask

    task automatic test_reset();
        rst1 = 1'b1;
        start1 = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy1, done1, pass1} !== 3'b000)
            $display("FAIL reset_flags: got %b want 000", {busy1, done1, pass1});
        checks++;
        if (sig1 !== 32'h0) $display("FAIL reset_sig: got %h want 00000000", sig1);
        checks++;
        if ({bus1.oA, bus1.oB, bus1.oCtrl} !== 67'h0)
            $display("FAIL reset_bus: got %h %h %h want 0", bus1.oA, bus1.oB, bus1.oCtrl);
        failures += int'({busy1, done1, pass1} !== 3'b000) + int'(sig1 !== 32'h0)
                  + int'({bus1.oA, bus1.oB, bus1.oCtrl} !== 67'h0);
        rst1 = 1'b0;
        @(negedge clk);
        start1 = 1'b0;
        checks++;
        if ({busy1, bus1.oA, bus1.oB, bus1.oCtrl} !== {1'b1, ONES, ONES, 3'd0}) begin
            failures++;
            $display("FAIL start_first: got busy=%b A=%h B=%h ctrl=%0d want busy=1 A=B=ffffffff ctrl=0",
                     busy1, bus1.oA, bus1.oB, bus1.oCtrl);
        end
    endtask

    task automatic test_corner();
        logic [31:0] exp_b;
        logic [31:0] exp_sig;
        rst2 = 1'b1;
        start2 = 1'b0;
        @(negedge clk);
        rst2 = 1'b0;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        for (int cyc = 1; cyc <= 16; cyc++) begin
            exp_b = (cyc <= 8) ? ONES : 32'h0;
            checks++;
            if ({bus2.oA, bus2.oB, bus2.oCtrl} !== {ONES, exp_b, 3'(cyc - 1)}) begin
                failures++;
                $display("FAIL corner_cyc%0d: got A=%h B=%h ctrl=%0d want A=%h B=%h ctrl=%0d",
                         cyc, bus2.oA, bus2.oB, bus2.oCtrl, ONES, exp_b, cyc - 1);
            end
            @(negedge clk);
        end
        checks++;
        if ({busy2, done2, bus2.oA, bus2.oB, bus2.oCtrl} !== {2'b10, 67'h0}) begin
            failures++;
            $display("FAIL corner_drain: got busy=%b done=%b A=%h ctrl=%0d want busy=1 done=0 bus=0",
                     busy2, done2, bus2.oA, bus2.oCtrl);
        end
        @(negedge clk);
        checks++;
        if ({busy2, done2} !== 2'b01) begin
            failures++;
            $display("FAIL corner_done18: got busy=%b done=%b want busy=0 done=1", busy2, done2);
        end
        exp_sig = calc_sig(2, 1'b0);
        checks++;
        if ({sig2, pass2} !== {exp_sig, (exp_sig == 32'h0)}) begin
            failures++;
            $display("FAIL corner_sig: got sig=%h pass=%b want sig=%h pass=%b",
                     sig2, pass2, exp_sig, (exp_sig == 32'h0));
        end
    endtask

    task automatic test_pass();
        int cyc;
        int busy_gap;
        reset1();
        launch1();
        cyc = 1;
        busy_gap = 0;
        while (done1 !== 1'b1 && cyc < 400) begin
            if (busy1 !== 1'b1) busy_gap++;
            if (cyc == 17) begin
                checks++;
                if ({bus1.oA, bus1.oB, bus1.oCtrl} !== {SEED_A, SEED_B, 3'd0}) begin
                    failures++;
                    $display("FAIL vec2_seed: got A=%h B=%h ctrl=%0d want A=%h B=%h ctrl=0",
                             bus1.oA, bus1.oB, bus1.oCtrl, SEED_A, SEED_B);
                end
            end
            if (cyc == 28) begin
                checks++;
                if ({bus1.oA, bus1.oB, bus1.oCtrl} !== {lstep(SEED_A), lstep(SEED_B), 3'd3}) begin
                    failures++;
                    $display("FAIL vec3_step: got A=%h B=%h ctrl=%0d want A=%h B=%h ctrl=3",
                             bus1.oA, bus1.oB, bus1.oCtrl, lstep(SEED_A), lstep(SEED_B));
                end
            end
            if (cyc == 129) begin
                checks++;
                if ({bus1.oA, bus1.oB, bus1.oCtrl} !== 67'h0) begin
                    failures++;
                    $display("FAIL drain_bus: got A=%h B=%h ctrl=%0d want 0",
                             bus1.oA, bus1.oB, bus1.oCtrl);
                end
            end
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc != 130) begin failures++; $display("FAIL pass_latency: got %0d want 130", cyc); end
        checks++;
        if (busy_gap != 0) begin failures++; $display("FAIL pass_busy_gap: got %0d want 0", busy_gap); end
        checks++;
        if ({busy1, pass1, sig1} !== {2'b01, GOLD16}) begin
            failures++;
            $display("FAIL pass_result: got busy=%b pass=%b sig=%h want busy=0 pass=1 sig=%h",
                     busy1, pass1, sig1, GOLD16);
        end
    endtask

    task automatic test_fault();
        int cyc;
        logic [31:0] exp_sig;
        reset1();
        fault = 1'b1;
        launch1();
        cyc = 1;
        while (done1 !== 1'b1 && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        fault = 1'b0;
        exp_sig = calc_sig(16, 1'b1);
        checks++;
        if (cyc != 130) begin failures++; $display("FAIL fault_latency: got %0d want 130", cyc); end
        checks++;
        if (pass1 !== 1'b0) begin failures++; $display("FAIL fault_pass: got %b want 0", pass1); end
        checks++;
        if (sig1 === GOLD16) begin failures++; $display("FAIL fault_sig_differs: got %h want not %h", sig1, GOLD16); end
        checks++;
        if (sig1 !== exp_sig) begin failures++; $display("FAIL fault_sig: got %h want %h", sig1, exp_sig); end
    endtask

    task automatic test_busy_restart();
        int cyc;
        reset1();
        launch1();
        cyc = 1;
        while (done1 !== 1'b1 && cyc < 400) begin
            start1 = (cyc == 5 || cyc == 50);
            @(negedge clk);
            cyc++;
        end
        start1 = 1'b0;
        checks++;
        if ({cyc == 130, sig1} !== {1'b1, GOLD16}) begin
            failures++;
            $display("FAIL busy_ignore: got cyc=%0d sig=%h want cyc=130 sig=%h", cyc, sig1, GOLD16);
        end
        launch1();
        checks++;
        if ({done1, pass1, busy1, bus1.oA, bus1.oB, bus1.oCtrl, sig1} !==
            {3'b001, ONES, ONES, 3'd0, 32'hFFFF_FFFF}) begin
            failures++;
            $display("FAIL restart_first: got done=%b pass=%b busy=%b A=%h ctrl=%0d sig=%h want 0 0 1 ffffffff 0 ffffffff",
                     done1, pass1, busy1, bus1.oA, bus1.oCtrl, sig1);
        end
        cyc = 1;
        while (done1 !== 1'b1 && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if ({cyc == 130, pass1, sig1} !== {2'b11, GOLD16}) begin
            failures++;
            $display("FAIL restart_run: got cyc=%0d pass=%b sig=%h want cyc=130 pass=1 sig=%h",
                     cyc, pass1, sig1, GOLD16);
        end
    endtask

    task automatic test_midrun_reset();
        reset1();
        launch1();
        repeat (39) @(negedge clk);
        checks++;
        if (busy1 !== 1'b1) begin failures++; $display("FAIL midrun_busy: got %b want 1", busy1); end
        rst1 = 1'b1;
        @(negedge clk);
        rst1 = 1'b0;
        checks++;
        if ({busy1, done1, sig1, bus1.oA, bus1.oB, bus1.oCtrl} !== 101'h0) begin
            failures++;
            $display("FAIL midrun_abort: got busy=%b done=%b sig=%h A=%h want all 0",
                     busy1, done1, sig1, bus1.oA);
        end
        repeat (10) @(negedge clk);
        checks++;
        if ({busy1, done1} !== 2'b00) begin
            failures++;
            $display("FAIL midrun_idle: got busy=%b done=%b want 00", busy1, done1);
        end
    endtask

    task automatic test_comb();
        int cyc;
        rst3 = 1'b1;
        start3 = 1'b0;
        @(negedge clk);
        rst3 = 1'b0;
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        cyc = 1;
        while (done3 !== 1'b1 && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc != 130) begin failures++; $display("FAIL comb_latency: got %0d want 130", cyc); end
        checks++;
        if ({busy3, pass3, sig3} !== {2'b01, GOLD16}) begin
            failures++;
            $display("FAIL comb_result: got busy=%b pass=%b sig=%h want busy=0 pass=1 sig=%h",
                     busy3, pass3, sig3, GOLD16);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        fault = 1'b0;
        rst1 = 1'b1;
        rst2 = 1'b1;
        rst3 = 1'b1;
        start1 = 1'b0;
        start2 = 1'b0;
        start3 = 1'b0;
        test_reset();
        test_corner();
        test_pass();
        test_fault();
        test_busy_restart();
        test_midrun_reset();
        test_comb();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu32_bist.md
# alu32_bist

Built-in self-test sequencer for the 32-bit ALU in the single-cycle processor; it is the driving end of the ALU operand/control interface. On a start request it drives `iA`, `iB` and `ctrl` through all 8 ALU opcodes for a programmable number of operand vectors. It compacts every ALU response (`out`, `oCarry`, `oZero`) into a 32-bit MISR signature and reports pass/fail against a golden signature. It sits beside the ALU behind a mux on the ALU inputs and is used for power-on and bench self-test.

## Interface
Parameters:
- `N_VEC`, 16: operand vectors per opcode; valid range 2..1024.
- `ALU_LAT`, 1: ALU response latency in clocks; valid values 0 (combinational) and 1 (registered).
- `SEED_A`, 32'hACE1_2468: LFSR seed for operand A.
- `SEED_B`, 32'h1357_9BDF: LFSR seed for operand B.
- `GOLDEN`, 32'h0000_0000: expected final signature.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `iStart`  in  1  start request; sampled only in IDLE or DONE.
- `oA`  out  32  operand A to the ALU `iA`.
- `oB`  out  32  operand B to the ALU `iB`.
- `oCtrl`  out  3  opcode to the ALU `ctrl`.
- `iOut`  in  32  ALU result.
- `iCarry`  in  1  ALU carry flag.
- `iZero`  in  1  ALU zero flag.
- `oBusy`  out  1  high in ISSUE and DRAIN.
- `oDone`  out  1  high in DONE (level), cleared by the next accepted start.
- `oPass`  out  1  valid while `oDone` is high; 1 when signature equals `GOLDEN`.
- `oSig`  out  32  current MISR signature.

## Operation
- **States and transitions.**
  - IDLE → ISSUE on `iStart`.
  - ISSUE → DRAIN after the last issue (vector N_VEC-1, ctrl 7).
  - DRAIN → DONE after ALU_LAT cycles. With ALU_LAT=0, DRAIN lasts one cycle and captures nothing.
  - DONE → ISSUE on `iStart`.
- **Start.** Accepting `iStart` loads MISR = 32'hFFFF_FFFF, loads LFSR_A=SEED_A and LFSR_B=SEED_B, and zeroes the vector and opcode counters. `iStart` is ignored in ISSUE and DRAIN.
- **Issue order.**
  - The opcode is the inner loop: it increments 0..7 every ISSUE cycle, then the vector index advances.
  - Total issue cycles = 8*N_VEC.
- **Operands.**
  - Vector 0: A=B=32'hFFFF_FFFF.
  - Vector 1: A=32'hFFFF_FFFF, B=32'h0000_0000.
  - Vectors ≥2: A=LFSR_A, B=LFSR_B. Both LFSRs step once per vector advance from vector 2 onward.
- **LFSR step.** Galois, right-shift: `step(x) = x[0] ? (x>>1) ^ POLY : (x>>1)`, POLY = 32'h8020_0003.
- **Compaction.** Each captured response updates `MISR <= step(MISR) ^ (iOut ^ {iCarry, iZero, 30'b0})`.
- **Capture pipeline.** Capture is gated by a valid shift register of depth ALU_LAT, fed with 1 on each ISSUE cycle. With ALU_LAT=0, capture happens in the same ISSUE cycle.
- **Outputs outside ISSUE.** `oA`, `oB` and `oCtrl` are 0.
- **Pass/fail.** On entry to DONE, `oPass` is registered as (final MISR == GOLDEN).
- **Reset.**
  - All outputs reset to 0; state = IDLE; MISR = 0.
  - Reset mid-run aborts immediately. No partial result is reported, and `oDone` stays 0.

## Timing
- `oA`, `oB`, `oCtrl`, `oBusy`, `oDone`, `oPass` and `oSig` are all registered.
- `iStart` high at edge E0 → first vector on `oA/oB/oCtrl` and `oBusy`=1 during the cycle after E0.
- Issue k is driven in cycle t_k. Its response is sampled at the rising edge ending cycle t_k+ALU_LAT.
- `oDone` rises 8*N_VEC + max(ALU_LAT,1) + 1 cycles after E0, and `oBusy` falls in the same cycle. Example: N_VEC=16, ALU_LAT=1 gives 130 cycles.
- `iStart` in DONE: `oDone` and `oPass` clear in the cycle after the edge, and issue restarts in that same cycle.
- `rst` and `iStart` asserted together: reset wins.

## Structure
- **Package `alu32_bist_pkg`:**
  - state encoding (IDLE, ISSUE, DRAIN, DONE);
  - POLY;
  - MISR init value 32'hFFFF_FFFF;
  - corner operand constants 32'hFFFF_FFFF and 32'h0;
  - the `step` function.
- **Sub-module `lfsr32`:**
  - parameters: seed and polynomial;
  - ports: load and enable;
  - used twice, for operands A and B.
- **Top-level only:** MISR update, counters, FSM and the valid pipeline.

## Test plan
- **Reset values.** Hold `rst` 3 cycles → all outputs 0, `oBusy`=0. Then `iStart` without `rst` → `oBusy`=1 after one cycle.
- **Corner vectors.** N_VEC=2 with the reference ALU model → cycles 1–8 show A=B=32'hFFFF_FFFF with ctrl 0..7, and cycles 9–16 show B=32'h0. Completion is reported 18 cycles after E0.
- **Pass.** Run N_VEC=16, ALU_LAT=1 against the bench ALU model, with GOLDEN set to the bench-computed signature → `oDone`=1 at cycle 130, `oPass`=1, `oSig`=GOLDEN.
- **Fault detection.** Same run, but the ALU model forces `oCarry`=0 for ctrl=3'b000 → `oPass`=0 and `oSig`≠GOLDEN.
- **Busy and restart.** Pulse `iStart` at cycles 5 and 50 mid-run → no restart; the signature matches an unperturbed run. `iStart` in DONE → a new run gives an identical `oSig`.
- **Mid-run reset and latency.** `rst` at cycle 40 → IDLE next cycle, with `oDone`=0 and `oSig`=0. Repeat the pass scenario with ALU_LAT=0 and a combinational model → `oPass`=1 at cycle 130 (8*16 + 1 + 1).
